// File: rtl/region_classifier.sv
// region_classifier: per-channel float exponent region classifier with a one-entry output skid buffer.
// Optional statistics counters are enabled by defining REGION_CLASSIFIER_STATS_EN.
module region_classifier #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int NUM_CH  = 4,
    parameter int SAT_EXP = 129,
    parameter int LIN_EXP = 123
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_CH*(1+EXP_W+MAN_W)-1:0]   in_data,
    input  logic                                cfg_we,
    input  logic [EXP_W-1:0]                    cfg_sat,
    input  logic [EXP_W-1:0]                    cfg_lin,
    output logic                                cfg_err,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_CH*3-1:0]                 out_region,
    output logic [NUM_CH-1:0]                   out_sign,
    output logic [NUM_CH*(1+EXP_W+MAN_W)-1:0]   out_data,
    input  logic [2:0]                          stat_sel,
    input  logic                                stat_clr,
    output logic [31:0]                         stat_count
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic [EXP_W-1:0]    sat_thr, lin_thr;
    logic [NUM_CH*3-1:0] in_region, skid_region;
    logic [NUM_CH-1:0]   in_sign, skid_sign;
    logic [NUM_CH*W-1:0] skid_data;
    logic                skid_valid, accept, out_free, cfg_ok;

    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;
    assign cfg_ok   = {1'b0, cfg_lin} <= {1'b0, cfg_sat} + (EXP_W+1)'(1);

    // Words are classified at acceptance, so later threshold writes never touch queued words.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        assign e          = in_data[c*W+MAN_W +: EXP_W];
        assign m          = in_data[c*W +: MAN_W];
        assign in_sign[c] = in_data[c*W+W-1];
        assign in_region[c*3 +: 3] = (&e && m != '0) ? 3'b100 :
                                     &e               ? 3'b001 :
                                     e == '0          ? 3'b011 :
                                     e > sat_thr      ? 3'b001 :
                                     e < lin_thr      ? 3'b010 : 3'b000;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sat_thr <= EXP_W'(SAT_EXP);
            lin_thr <= EXP_W'(LIN_EXP);
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_we && cfg_ok) begin
                sat_thr <= cfg_sat;
                lin_thr <= cfg_lin;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_region  <= '1;
            out_sign    <= '0;
            out_data    <= '0;
            skid_valid  <= 1'b0;
            skid_region <= '0;
            skid_sign   <= '0;
            skid_data   <= '0;
            in_ready    <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_region <= skid_region;
                out_sign   <= skid_sign;
                out_data   <= skid_data;
            end else if (accept) begin
                out_region <= in_region;
                out_sign   <= in_sign;
                out_data   <= in_data;
            end
            out_valid  <= skid_valid || accept;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (accept) begin
            skid_region <= in_region;
            skid_sign   <= in_sign;
            skid_data   <= in_data;
            skid_valid  <= 1'b1;
            in_ready    <= 1'b0;
        end
    end

`ifdef REGION_CLASSIFIER_STATS_EN
    // Index 0..4 hold codes 000..100, index 5 holds code 111.
    logic [31:0] cnt [6];
    logic [32:0] sum [6];

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            sum[i] = {1'b0, cnt[i]};
            for (int c = 0; c < NUM_CH; c++)
                sum[i] = sum[i] + 33'(out_region[c*3 +: 3] == (i == 5 ? 3'd7 : 3'(i)));
        end
    end

    always_ff @(posedge clock) begin
        if (reset || stat_clr) begin
            for (int i = 0; i < 6; i++) cnt[i] <= '0;
        end else if (out_valid && out_ready) begin
            for (int i = 0; i < 6; i++) cnt[i] <= sum[i][32] ? '1 : sum[i][31:0];
        end
    end

    assign stat_count = stat_sel == 3'b111 ? cnt[5] : stat_sel > 3'b100 ? '0 : cnt[stat_sel];
`else
    logic unused_stat;
    assign unused_stat = ^{stat_sel, stat_clr};
    assign stat_count  = '0;
`endif

endmodule

// File: doc/region_classifier.md
REGION_CLASSIFIER -- requirements
Module: region_classifier

Interface
REQ-001 SHALL have parameters: EXP_W, default 8, exponent field width; MAN_W, default 23, mantissa field width; NUM_CH, default 4, parallel channels; SAT_EXP, default 129, reset saturation threshold; LIN_EXP, default 123, reset linear threshold.
REQ-002 SHALL define W = 1+EXP_W+MAN_W, the per-channel word {sign, exponent, mantissa}; channel k occupies bits [k*W +: W].
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have these ports, one per line as name, direction, width, meaning:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept input
- in_data  in  NUM_CH*W  packed float inputs
- cfg_we  in  1  threshold write strobe
- cfg_sat  in  EXP_W  new saturation threshold
- cfg_lin  in  EXP_W  new linear threshold
- cfg_err  out  1  one-cycle pulse: rejected config write
- out_valid  out  1  output valid
- out_ready  in  1  downstream can accept
- out_region  out  NUM_CH*3  per-channel region code
- out_sign  out  NUM_CH  per-channel sign bit
- out_data  out  NUM_CH*W  input words passed through, aligned with codes
- stat_sel  in  3  region code whose count is read
- stat_clr  in  1  clear all statistics counters
- stat_count  out  32  selected counter value

Function
REQ-005 SHALL classify each channel on exponent e and mantissa m, first match wins: e all-ones and m!=0 -> 3'b100 NaN; e all-ones and m==0 -> 3'b001 saturation; e==0 -> 3'b011 zero/denormal; e>sat_thr -> 3'b001; e<lin_thr -> 3'b010 linear; otherwise 3'b000 hyperbolic.
REQ-006 SHALL compare exponents unsigned at EXP_W bits; sign does not affect the code.
REQ-007 SHALL accept input when in_valid and in_ready are both high and present the result one cycle later, with out_valid high.
REQ-008 SHALL hold out_region, out_sign and out_data stable while out_valid is high and out_ready is low.
REQ-009 SHALL contain a one-entry skid buffer; in_ready is registered, low only while the skid entry is occupied; no accepted word is dropped or duplicated.
REQ-010 SHALL sustain one transfer per cycle when out_ready is continuously high.
REQ-011 SHALL preserve acceptance order on the output.
REQ-012 SHALL load sat_thr and lin_thr from cfg_sat and cfg_lin on cfg_we when cfg_lin <= cfg_sat+1; the new values apply to words accepted from the following cycle.
REQ-013 SHALL apply the old thresholds to a word accepted in the same cycle as cfg_we.
REQ-014 SHALL ignore a write with cfg_lin > cfg_sat+1, keep the old thresholds, and pulse cfg_err high for exactly one cycle.
REQ-015 SHALL use the registered copy for a word held in the skid buffer, so a later config write does not reclassify it.

Reset
REQ-016 SHALL, while reset is high, drive out_valid=0, in_ready=0, cfg_err=0, every out_region channel=3'b111, out_sign=0, out_data=0, sat_thr=SAT_EXP, lin_thr=LIN_EXP, and empty the skid buffer.
REQ-017 SHALL drive in_ready=1 on the first cycle after reset deasserts.
REQ-018 SHALL discard in-flight words on reset asserted mid-operation.

Configuration
REQ-019 SHALL provide macro REGION_CLASSIFIER_STATS_EN.
- Defined: six 32-bit counters, for codes 000, 001, 010, 011, 100 and 111; each output handshake adds the number of channels carrying that code; counters saturate at 32'hFFFFFFFF; stat_clr zeroes all counters, and clear wins over a same-cycle increment; stat_count = counter[stat_sel], which reads 0 for codes 101 and 110; reset clears all counters.
- Undefined: no counters; stat_count tied to 0; ports remain present.

Verification
REQ-020 SHALL pass, at defaults, these directed scenarios:
- Inputs 0x3F800000, 0x41200000, 0x3C000000, 0x3E800000 (e=127, 130, 120, 125) -> codes 000, 001, 010, 000, one cycle after acceptance.
- 0x7FC00000, 0xFF800000, 0x00000001, 0x80000000 -> codes 100, 001, 011, 011; out_sign=4'b1010.
- out_ready low for 3 cycles while in_valid is held high -> in_ready drops after the skid fills; releasing out_ready delivers both words in order with no loss.
- cfg_we with sat=130, lin=120 in the same cycle as accepting e=130 -> that word gets 001 and the next e=130 word gets 000; cfg_we with lin=140, sat=130 -> cfg_err pulses one cycle and thresholds are unchanged.
- Reset asserted with out_valid high -> next cycle out_valid=0 and codes 3'b111; if STATS_EN, 10 transfers of four hyperbolic channels -> stat_sel=0 reads 40.
